ddr_address_increment: RTL and testbench
========================================

Name: ddr_address_increment

Overview:
Burst address generator for the DDR controller. It is loaded with a starting bank/row/column and a burst count. On each `advance` strobe it steps the column by one burst, carrying into row and then bank. It sits between the command scheduler, which issues `advance` per READ/WRITE, and the command/address output path.

Parameters:
- BANK_W, 3, bank address width
- ROW_W, 14, row address width
- COL_W, 10, column address width
- BURST_LEN, 8, column step per burst; power of two, must be less than 2**COL_W
- CNT_W, 8, width of burst counter

Ports:
- clk  in  1  system clock; all logic on rising edge
- n_rst  in  1  synchronous reset, active-high (1 = reset), sampled on rising clk
- load  in  1  start a new sequence
- base_bank  in  BANK_W  starting bank
- base_row  in  ROW_W  starting row
- base_col  in  COL_W  starting column
- num_bursts  in  CNT_W  number of bursts in the sequence
- advance  in  1  current burst consumed; step address
- bank  out  BANK_W  current bank (registered)
- row  out  ROW_W  current row (registered)
- col  out  COL_W  current column (registered)
- busy  out  1  sequence in progress (registered)
- last  out  1  current address is the final burst (combinational: busy && remaining==1)
- done  out  1  one-cycle pulse, registered, after final advance
- wrapped  out  1  one-cycle pulse, registered, when the bank counter wraps past max

Behaviour:
- Reset (n_rst=1 at a clk edge): bank/row/col=0, remaining=0, busy=0, done=0, wrapped=0, state IDLE.
- States: IDLE, ACTIVE.
- IDLE, load=1, num_bursts!=0:
  - next cycle bank=base_bank, row=base_row, col=base_col with low log2(BURST_LEN) bits cleared (aligned);
  - remaining=num_bursts, busy=1, state ACTIVE.
- IDLE, load=1, num_bursts==0: addresses load as above, busy stays 0, done pulses next cycle.
- IDLE: advance ignored. load has priority over a same-cycle advance.
- ACTIVE, advance=1, remaining>1:
  - col += BURST_LEN;
  - if col would reach or exceed 2**COL_W: col=0, row+=1;
  - if row overflows: row=0, bank+=1;
  - if bank overflows: bank=0, wrapped=1 for one cycle;
  - remaining -= 1.
- ACTIVE, advance=1, remaining==1: address holds, remaining=0, busy=0, done=1 for one cycle, state IDLE.
- ACTIVE: load is ignored (no restart mid-sequence).
- ACTIVE, advance=0: all state holds.
- Latency: address change visible the cycle after the `advance` edge. `last` reflects the present state with zero latency.
- Reset asserted mid-sequence aborts immediately to reset values. No done pulse is generated.
- Back-to-back advance every cycle is supported with no bubbles.

Optional Feature:
- Macro ADDR_INC_INTERLEAVE_EN.
- When defined, the step order becomes bank-first:
  - each advance does bank+=1;
  - on bank wrap to 0, col+=BURST_LEN;
  - col carries into row;
  - row wrap pulses `wrapped`.
- When undefined, the column-first order above applies and no interleave logic is synthesized.

Test Plan:
- Reset: hold n_rst=1 two cycles -> bank/row/col=0, busy=0, done=0, wrapped=0, last=0.
- Simple sequence: load bank=2,row=5,col=0x13,num_bursts=3 -> col=0x10, busy=1; three advances -> col 0x18, 0x20, then hold at 0x20 with done pulse; last=1 only while remaining==1.
- Column carry: load col=0x3F8,row=7,num_bursts=2; advance -> col=0, row=8, bank unchanged.
- Full wrap: load bank=7,row=0x3FFF,col=0x3F8,num_bursts=2; advance -> bank=0,row=0,col=0, wrapped pulses exactly one cycle.
- Priority/ignore: load while busy -> no change; load+advance in IDLE -> load taken, no step; num_bursts=0 -> done pulse, busy stays 0.
- Mid-sequence reset: assert n_rst during ACTIVE -> next cycle all outputs zero, no done pulse.

Source files
------------

// File: rtl/ddr_address_increment_if.sv
// Bus between the command scheduler (master) and the burst address
// generator (slave): load/advance controls in, bank/row/col and status out.
interface ddr_address_increment_if #(
  parameter int BANK_W = 3,
  parameter int ROW_W  = 14,
  parameter int COL_W  = 10,
  parameter int CNT_W  = 8
);
  logic              load;
  logic [BANK_W-1:0] base_bank;
  logic [ROW_W-1:0]  base_row;
  logic [COL_W-1:0]  base_col;
  logic [CNT_W-1:0]  num_bursts;
  logic              advance;
  logic [BANK_W-1:0] bank;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              busy;
  logic              last;
  logic              done;
  logic              wrapped;

  modport master (
    output load, base_bank, base_row, base_col, num_bursts, advance,
    input  bank, row, col, busy, last, done, wrapped
  );

  modport slave (
    input  load, base_bank, base_row, base_col, num_bursts, advance,
    output bank, row, col, busy, last, done, wrapped
  );
endinterface

// File: rtl/ddr_address_increment.sv
// Burst address generator for the DDR controller.
// Loaded with a start bank/row/col and a burst count; each advance steps
// the address by one burst. Column-first carry order by default; defining
// ADDR_INC_INTERLEAVE_EN switches to bank-first (bank -> col -> row) order.
//
// state    | meaning
// S_IDLE   | waiting for load; advance ignored
// S_ACTIVE | sequence running; load ignored, advance steps the address
module ddr_address_increment #(
  parameter int BANK_W    = 3,
  parameter int ROW_W     = 14,
  parameter int COL_W     = 10,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 8
) (
  input logic                      clk,
  input logic                      n_rst,
  ddr_address_increment_if.slave   bus
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  localparam logic [COL_W:0]   STEP      = (COL_W+1)'(BURST_LEN);
  localparam logic [COL_W-1:0] ALIGN_MSK = ~(COL_W'(BURST_LEN - 1));

  state_t            r_state;
  logic [BANK_W-1:0] r_bank;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_busy;
  logic              r_done;
  logic              r_wrapped;

  logic [COL_W:0]    w_col_sum;
  logic [ROW_W:0]    w_row_sum;
  logic [BANK_W:0]   w_bank_sum;
  logic              w_col_cy;
  logic              w_row_cy;
  logic              w_bank_cy;
  logic [BANK_W-1:0] w_nxt_bank;
  logic [ROW_W-1:0]  w_nxt_row;
  logic [COL_W-1:0]  w_nxt_col;
  logic              w_nxt_wrap;

  // Increment candidates and their carries; columns stay burst-aligned so
  // the column sum lands exactly on 2**COL_W when it carries.
  assign w_col_sum  = {1'b0, r_col} + STEP;
  assign w_row_sum  = {1'b0, r_row} + (ROW_W+1)'(1);
  assign w_bank_sum = {1'b0, r_bank} + (BANK_W+1)'(1);
  assign w_col_cy   = w_col_sum[COL_W];
  assign w_row_cy   = w_row_sum[ROW_W];
  assign w_bank_cy  = w_bank_sum[BANK_W];

`ifdef ADDR_INC_INTERLEAVE_EN
  // Bank-first: bank every advance, column on bank wrap, row on column wrap.
  assign w_nxt_bank = w_bank_sum[BANK_W-1:0];
  assign w_nxt_col  = w_bank_cy ? (w_col_cy ? '0 : w_col_sum[COL_W-1:0]) : r_col;
  assign w_nxt_row  = (w_bank_cy && w_col_cy) ? w_row_sum[ROW_W-1:0] : r_row;
  assign w_nxt_wrap = w_bank_cy && w_col_cy && w_row_cy;
`else
  // Column-first: column every advance, row on column wrap, bank on row wrap.
  assign w_nxt_col  = w_col_cy ? '0 : w_col_sum[COL_W-1:0];
  assign w_nxt_row  = w_col_cy ? w_row_sum[ROW_W-1:0] : r_row;
  assign w_nxt_bank = (w_col_cy && w_row_cy) ? w_bank_sum[BANK_W-1:0] : r_bank;
  assign w_nxt_wrap = w_col_cy && w_row_cy && w_bank_cy;
`endif

  // Sequence FSM with registered address, status and pulse outputs.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_state     <= S_IDLE;
      r_bank      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wrapped   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_wrapped <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.load) begin
            r_bank      <= bus.base_bank;
            r_row       <= bus.base_row;
            r_col       <= bus.base_col & ALIGN_MSK;
            r_remaining <= bus.num_bursts;
            if (bus.num_bursts != '0) begin
              r_busy  <= 1'b1;
              r_state <= S_ACTIVE;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_ACTIVE: begin
          if (bus.advance) begin
            if (r_remaining > CNT_W'(1)) begin
              r_bank      <= w_nxt_bank;
              r_row       <= w_nxt_row;
              r_col       <= w_nxt_col;
              r_wrapped   <= w_nxt_wrap;
              r_remaining <= r_remaining - CNT_W'(1);
            end else begin
              r_remaining <= '0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.bank    = r_bank;
  assign bus.row     = r_row;
  assign bus.col     = r_col;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.wrapped = r_wrapped;
  assign bus.last    = r_busy && (r_remaining == CNT_W'(1));

endmodule

// File: tb/tb_ddr_address_increment.sv
// Directed bench for ddr_address_increment (default column-first build).
module tb_ddr_address_increment;
  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;

  ddr_address_increment_if u_if ();

  ddr_address_increment u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_seq(input logic [2:0] b, input logic [13:0] r,
                          input logic [9:0] c, input logic [7:0] n);
    u_if.load       = 1'b1;
    u_if.base_bank  = b;
    u_if.base_row   = r;
    u_if.base_col   = c;
    u_if.num_bursts = n;
  endtask

  initial begin
    n_rst = 1'b1;
    u_if.load = 1'b0; u_if.advance = 1'b0;
    u_if.base_bank = '0; u_if.base_row = '0; u_if.base_col = '0; u_if.num_bursts = '0;

    // reset
    tick(); tick();
    chk("rst_bank", 32'(u_if.bank), 0);
    chk("rst_row", 32'(u_if.row), 0);
    chk("rst_col", 32'(u_if.col), 0);
    chk("rst_busy", 32'(u_if.busy), 0);
    chk("rst_done", 32'(u_if.done), 0);
    chk("rst_wrapped", 32'(u_if.wrapped), 0);
    chk("rst_last", 32'(u_if.last), 0);
    n_rst = 1'b0;
    tick();

    // simple sequence, unaligned start column
    load_seq(3'd2, 14'd5, 10'h13, 8'd3);
    tick(); u_if.load = 1'b0;
    chk("seq_col0", 32'(u_if.col), 32'h10);
    chk("seq_bank0", 32'(u_if.bank), 2);
    chk("seq_row0", 32'(u_if.row), 5);
    chk("seq_busy0", 32'(u_if.busy), 1);
    chk("seq_last0", 32'(u_if.last), 0);
    u_if.advance = 1'b1;
    tick();
    chk("seq_col1", 32'(u_if.col), 32'h18);
    chk("seq_last1", 32'(u_if.last), 0);
    tick();
    chk("seq_col2", 32'(u_if.col), 32'h20);
    chk("seq_last2", 32'(u_if.last), 1);
    chk("seq_busy2", 32'(u_if.busy), 1);
    tick();
    chk("seq_col3", 32'(u_if.col), 32'h20);
    chk("seq_done3", 32'(u_if.done), 1);
    chk("seq_busy3", 32'(u_if.busy), 0);
    chk("seq_last3", 32'(u_if.last), 0);
    u_if.advance = 1'b0;
    tick();
    chk("seq_done_clr", 32'(u_if.done), 0);
    chk("seq_col_hold", 32'(u_if.col), 32'h20);

    // column carry into row
    load_seq(3'd3, 14'd7, 10'h3F8, 8'd2);
    tick(); u_if.load = 1'b0;
    chk("cy_col0", 32'(u_if.col), 32'h3F8);
    tick();
    chk("cy_hold_col", 32'(u_if.col), 32'h3F8);
    u_if.advance = 1'b1;
    tick(); u_if.advance = 1'b0;
    chk("cy_col", 32'(u_if.col), 0);
    chk("cy_row", 32'(u_if.row), 8);
    chk("cy_bank", 32'(u_if.bank), 3);
    chk("cy_wrapped", 32'(u_if.wrapped), 0);
    chk("cy_last", 32'(u_if.last), 1);
    u_if.advance = 1'b1;
    tick(); u_if.advance = 1'b0;
    chk("cy_done", 32'(u_if.done), 1);
    tick();

    // full wrap of bank/row/col
    load_seq(3'd7, 14'h3FFF, 10'h3F8, 8'd2);
    tick(); u_if.load = 1'b0;
    u_if.advance = 1'b1;
    tick(); u_if.advance = 1'b0;
    chk("wr_bank", 32'(u_if.bank), 0);
    chk("wr_row", 32'(u_if.row), 0);
    chk("wr_col", 32'(u_if.col), 0);
    chk("wr_pulse", 32'(u_if.wrapped), 1);
    tick();
    chk("wr_pulse_clr", 32'(u_if.wrapped), 0);
    chk("wr_busy", 32'(u_if.busy), 1);
    u_if.advance = 1'b1;
    tick(); u_if.advance = 1'b0;
    chk("wr_done", 32'(u_if.done), 1);
    chk("wr_nowrap", 32'(u_if.wrapped), 0);
    tick();

    // load ignored while busy, then mid-sequence reset
    load_seq(3'd1, 14'd1, 10'h000, 8'd4);
    tick();
    load_seq(3'd5, 14'd9, 10'h100, 8'd2);
    tick(); u_if.load = 1'b0;
    chk("ign_bank", 32'(u_if.bank), 1);
    chk("ign_row", 32'(u_if.row), 1);
    chk("ign_col", 32'(u_if.col), 0);
    u_if.advance = 1'b1;
    tick(); u_if.advance = 1'b0;
    chk("ign_step_col", 32'(u_if.col), 8);
    n_rst = 1'b1;
    tick();
    chk("mrst_bank", 32'(u_if.bank), 0);
    chk("mrst_row", 32'(u_if.row), 0);
    chk("mrst_col", 32'(u_if.col), 0);
    chk("mrst_busy", 32'(u_if.busy), 0);
    chk("mrst_done", 32'(u_if.done), 0);
    n_rst = 1'b0;
    tick();
    chk("mrst_done2", 32'(u_if.done), 0);

    // load + advance together in IDLE: load wins, no step
    load_seq(3'd4, 14'd2, 10'h00C, 8'd2);
    u_if.advance = 1'b1;
    tick(); u_if.load = 1'b0;
    chk("la_col", 32'(u_if.col), 32'h08);
    chk("la_bank", 32'(u_if.bank), 4);
    chk("la_last", 32'(u_if.last), 0);
    tick();
    chk("la_col1", 32'(u_if.col), 32'h10);
    chk("la_last1", 32'(u_if.last), 1);
    tick(); u_if.advance = 1'b0;
    chk("la_done", 32'(u_if.done), 1);
    tick();

    // zero-length sequence, then advance in IDLE ignored
    load_seq(3'd6, 14'd3, 10'h021, 8'd0);
    tick(); u_if.load = 1'b0;
    chk("z_col", 32'(u_if.col), 32'h20);
    chk("z_bank", 32'(u_if.bank), 6);
    chk("z_busy", 32'(u_if.busy), 0);
    chk("z_done", 32'(u_if.done), 1);
    u_if.advance = 1'b1;
    tick(); u_if.advance = 1'b0;
    chk("z_done_clr", 32'(u_if.done), 0);
    chk("z_idle_adv", 32'(u_if.col), 32'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
